// File: rtl/rr_arb64x8_pkg.sv
// Shared types and constants for the rr_arb64x8 round-robin burst arbiter.
package rr_arb64x8_pkg;

  localparam int N_REQ          = 8;
  localparam int SEL_W          = 3;
  localparam int DATA_W_DEFAULT = 64;
  localparam int BEAT_W_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb64x8_pick8.sv
// Rotating-priority encoder: first set req bit at or above ptr, wrapping 7->0.
module rr_pick8
  import rr_arb64x8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb64x8.sv
// Round-robin burst arbiter: eight requesters share one DATA_W result bus.
// Optional macro RR_ARB64X8_B2B_EN re-arbitrates on the last beat (no IDLE bubble).
//
// state | meaning
// IDLE  | no grant; arbitrate among req starting at ptr
// XFER  | burst in flight for requester sel; one beat per accept
module rr_arb64x8
  import rr_arb64x8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int BEAT_W = BEAT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*BEAT_W-1:0]   len,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  output logic [N_REQ-1:0]          in_ready,
  output logic [N_REQ-1:0]          gnt,
  output logic [SEL_W-1:0]          sel,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [BEAT_W-1:0] beats_left_q, beats_left_d;

  logic [SEL_W-1:0]  pick_ptr, pick_idx;
  logic              pick_any;
  logic [BEAT_W-1:0] pick_len;
  logic              accept;

  // In XFER the only use of the picker is back-to-back re-arbitration,
  // which must start just past the burst that is finishing.
  assign pick_ptr = (state_q == XFER) ? sel_q + SEL_W'(1) : ptr_q;

  rr_pick8 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_len  = len[int'(pick_idx)*BEAT_W +: BEAT_W];

  assign out_valid = (state_q == XFER);
  assign out_data  = out_valid ? in_data[int'(sel_q)*DATA_W +: DATA_W] : '0;
  assign out_last  = out_valid & (beats_left_q == '0);
  assign accept    = out_valid & out_ready;
  assign in_ready  = gnt_q & {N_REQ{accept}};
  assign gnt       = gnt_q;
  assign sel       = sel_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d        = onehot(pick_idx);
          sel_d        = pick_idx;
          beats_left_d = pick_len;
          state_d      = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (beats_left_q != '0) begin
            beats_left_d = beats_left_q - BEAT_W'(1);
          end else begin
            ptr_d   = sel_q + SEL_W'(1);
            gnt_d   = '0;
            state_d = IDLE;
`ifdef RR_ARB64X8_B2B_EN
            if (pick_any) begin
              gnt_d        = onehot(pick_idx);
              sel_d        = pick_idx;
              beats_left_d = pick_len;
              state_d      = XFER;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      gnt_q        <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule

// File: tb/tb_rr_arb64x8.sv
// Self-checking bench for rr_arb64x8: vector table plus scoreboarded burst sequences.
module tb_rr_arb64x8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   req;
  logic [31:0]  len;
  logic [511:0] in_data;
  logic [7:0]   in_ready;
  logic [7:0]   gnt;
  logic [2:0]   sel;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_last;
  logic         out_ready;

  always #5 clk = ~clk;

  rr_arb64x8 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .len       (len),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [2:0] idx;
    int         beat;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0]  req;
    logic [31:0] len;
    logic        rdy;
    int          pidx;
    int          pcnt;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        vld;
    logic        last;
    logic [7:0]  ir;
  } vec_t;

  exp_t sbq[$];
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   beat_cnt[8];
  int   exp_cnt[8];
  int   cyc_n = 0;
  int   stop_at = -1;
  vec_t tv[12];

  function automatic logic [63:0] mk(input int i, input int b);
    return {8'hA0 + 8'(i), 24'h5A5A5A, 32'(b)};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endfunction

  function automatic void push_burst(input int idx, input int n);
    for (int b = 0; b < n; b++) begin
      sbq.push_back('{idx: 3'(idx), beat: exp_cnt[idx], last: (b == n - 1)});
      exp_cnt[idx]++;
    end
  endfunction

  task automatic sample();
    for (int i = 0; i < 8; i++) in_data[i*64 +: 64] = mk(i, beat_cnt[i]);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    if (out_valid && out_ready) begin
      acc_log.push_back(cyc_n);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual sel=%0d required=no beat", sel);
      end else begin
        e = sbq.pop_front();
        chk("beat_sel", 64'(sel), 64'(e.idx));
        chk("beat_data", out_data, mk(e.idx, e.beat));
        chk("beat_last", 64'(out_last), 64'(e.last));
        chk("beat_in_ready", 64'(in_ready), 64'(8'h01 << e.idx));
        chk("beat_gnt", 64'(gnt), 64'(8'h01 << e.idx));
      end
      for (int i = 0; i < 8; i++) if (in_ready[i]) beat_cnt[i]++;
      if (acc_log.size() == stop_at) req = 8'h00;
    end else begin
      chk("noacc_in_ready", 64'(in_ready), 64'h0);
      if (!out_valid) chk("idle_out_data", out_data, 64'h0);
    end
  endtask

  task automatic advance();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic cyc();
    sample();
    monitor();
    advance();
  endtask

  task automatic run_until_gnt(input logic [7:0] g, input string name);
    bit hit = 1'b0;
    for (int k = 0; k < 12 && !hit; k++) begin
      cyc();
      hit = (gnt == g);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s_timeout actual gnt=%0h required=%0h", name, gnt, g);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((out_valid || gnt != 8'h00) && k < 40) begin
      cyc();
      k++;
    end
    cyc();
    chk({name, "_drained"}, 64'(out_valid), 64'h0);
    chk({name, "_sb_empty"}, 64'(sbq.size()), 64'h0);
  endtask

  initial begin
    int base;
    int gap;
    int exp_gap;
    bit done;

    //        req    len            rdy pidx pcnt gnt    sel  vld   last  ir
    tv[0]  = '{8'h00, 32'h0000_0000, 1'b1, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{8'h08, 32'h0000_0000, 1'b1, 3, 1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{8'h00, 32'h0000_0000, 1'b1, 0, 0, 8'h08, 3'd3, 1'b1, 1'b1, 8'h08};
    tv[3]  = '{8'h00, 32'h0000_0000, 1'b1, 0, 0, 8'h00, 3'd3, 1'b0, 1'b0, 8'h00};
    tv[4]  = '{8'h20, 32'h0030_0000, 1'b1, 5, 4, 8'h00, 3'd3, 1'b0, 1'b0, 8'h00};
    tv[5]  = '{8'h00, 32'h0030_0000, 1'b1, 0, 0, 8'h20, 3'd5, 1'b1, 1'b0, 8'h20};
    tv[6]  = '{8'h01, 32'h0000_0000, 1'b0, 0, 0, 8'h20, 3'd5, 1'b1, 1'b0, 8'h00};
    tv[7]  = '{8'h01, 32'h0000_0000, 1'b1, 0, 0, 8'h20, 3'd5, 1'b1, 1'b0, 8'h20};
    tv[8]  = '{8'h01, 32'h0000_0000, 1'b0, 0, 0, 8'h20, 3'd5, 1'b1, 1'b0, 8'h00};
    tv[9]  = '{8'h01, 32'h0000_0000, 1'b1, 0, 0, 8'h20, 3'd5, 1'b1, 1'b0, 8'h20};
    tv[10] = '{8'h00, 32'h0000_0000, 1'b1, 0, 0, 8'h20, 3'd5, 1'b1, 1'b1, 8'h20};
    tv[11] = '{8'h00, 32'h0000_0000, 1'b1, 0, 0, 8'h00, 3'd5, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 8; i++) begin
      beat_cnt[i] = 0;
      exp_cnt[i]  = 0;
    end
    reset_n   = 1'b0;
    req       = 8'h00;
    len       = 32'h0;
    out_ready = 1'b0;
    in_data   = '0;
    #22;
    @(negedge clk);
    reset_n = 1'b1;

    // Single request, then a backpressured 4-beat burst on requester 5.
    for (int r = 0; r < 12; r++) begin
      req       = tv[r].req;
      len       = tv[r].len;
      out_ready = tv[r].rdy;
      if (tv[r].pcnt > 0) push_burst(tv[r].pidx, tv[r].pcnt);
      sample();
      chk($sformatf("row%0d_gnt", r), 64'(gnt), 64'(tv[r].gnt));
      chk($sformatf("row%0d_sel", r), 64'(sel), 64'(tv[r].sel));
      chk($sformatf("row%0d_valid", r), 64'(out_valid), 64'(tv[r].vld));
      chk($sformatf("row%0d_last", r), 64'(out_last), 64'(tv[r].last));
      chk($sformatf("row%0d_in_ready", r), 64'(in_ready), 64'(tv[r].ir));
      monitor();
      advance();
    end
    chk("table_sb_empty", 64'(sbq.size()), 64'h0);

    // Finish a burst on requester 2 so ptr=3, then 6 must beat 2.
    req = 8'h04;
    len = 32'h0;
    push_burst(2, 1);
    cyc();
    req = 8'h00;
    cyc();
    cyc();
    push_burst(6, 1);
    push_burst(2, 1);
    req = 8'h44;
    run_until_gnt(8'h04, "ptr_prio");
    req = 8'h00;
    drain("ptr_prio");

    // Asynchronous reset during beat 2 of a 4-beat burst on requester 1.
    req = 8'h02;
    len = 32'h0000_0030;
    cyc();
    req = 8'h00;
    sbq.push_back('{idx: 3'd1, beat: exp_cnt[1], last: 1'b0});
    exp_cnt[1]++;
    sbq.push_back('{idx: 3'd1, beat: exp_cnt[1], last: 1'b0});
    exp_cnt[1]++;
    cyc();
    cyc();
    sample();
    chk("pre_reset_valid", 64'(out_valid), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_sel", 64'(sel), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_last", 64'(out_last), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_sb_empty", 64'(sbq.size()), 64'h0);
    advance();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) beat_cnt[i] = exp_cnt[i];

    // After reset ptr=0, so 0 wins over 7.
    req = 8'h81;
    len = 32'h0;
    push_burst(0, 1);
    push_burst(7, 1);
    run_until_gnt(8'h80, "post_rst");
    req = 8'h00;
    drain("post_rst");

    // Rotation through all eight with ptr wrapping back to 0.
    base    = acc_log.size();
    stop_at = base + 9;
    for (int i = 0; i < 8; i++) push_burst(i, 1);
    push_burst(0, 1);
    req  = 8'hFF;
    len  = 32'h0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc();
      done = (acc_log.size() >= stop_at);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rotation_timeout actual beats=%0d required=9", acc_log.size() - base);
      req = 8'h00;
    end
    stop_at = -1;
    drain("rotation");
`ifdef RR_ARB64X8_B2B_EN
    exp_gap = 8;
`else
    exp_gap = 16;
`endif
    gap = (acc_log.size() >= base + 9) ? acc_log[base + 8] - acc_log[base] : -1;
    chk("rotation_span", 64'(gap), 64'(exp_gap));

    // Two single-beat bursts: bubble between them only without back-to-back mode.
    base = acc_log.size();
    push_burst(1, 1);
    push_burst(2, 1);
    req = 8'h06;
    len = 32'h0;
    run_until_gnt(8'h04, "b2b");
    req = 8'h00;
    drain("b2b");
`ifdef RR_ARB64X8_B2B_EN
    exp_gap = 1;
`else
    exp_gap = 2;
`endif
    gap = (acc_log.size() >= base + 2) ? acc_log[base + 1] - acc_log[base] : -1;
    chk("b2b_gap", 64'(gap), 64'(exp_gap));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
